// File: rtl/tt_proj_sel_ctrl_pkg.sv
// Shared types and constants for the tile project select controller.
// Bit positions inside the packed tile input word live here.
package tt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISABLE = 2'd1,
        RESET   = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam int IW_CLK_BIT = 0;
    localparam int IW_RST_BIT = 1;
    localparam int IW_W_DEF   = 18;
    localparam int OW_W_DEF   = 24;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_proj_sel_ctrl_if.sv
// Select command channel and controller status bundle.
// The master issues commands; the controller is the slave.
interface tt_proj_sel_ctrl_if #(
    parameter int ADDR_W = 4
) ();

    logic              sel_valid;
    logic              sel_off;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ready;
    logic              sel_err;
    logic              busy;
    logic              active_valid;
    logic [ADDR_W-1:0] active_addr;

    modport master (
        output sel_valid, sel_off, sel_addr,
        input  sel_ready, sel_err, busy, active_valid, active_addr
    );

    modport slave (
        input  sel_valid, sel_off, sel_addr,
        output sel_ready, sel_err, busy, active_valid, active_addr
    );

endinterface

// File: rtl/tt_ow_mux.sv
// N_PROJ:1 tile output word mux; drives zero when no tile is enabled.
module tt_ow_mux
    import tt_ctrl_pkg::*;
#(
    parameter int N_PROJ = 16,
    parameter int ADDR_W = 4,
    parameter int OW_W   = OW_W_DEF
) (
    input  logic [ADDR_W-1:0]      sel_i,
    input  logic                   en_i,
    input  logic [N_PROJ*OW_W-1:0] data_i,
    output logic [OW_W-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N_PROJ; i++) begin
            if (en_i && (int'(sel_i) == i)) begin
                data_o = data_i[i*OW_W +: OW_W];
            end
        end
    end

endmodule

// File: rtl/tt_proj_sel_ctrl.sv
// Shares the user pins between tiles: safe switch sequencing
// (disable, gated clock with forced reset, run) and pin routing.
module tt_proj_sel_ctrl
    import tt_ctrl_pkg::*;
#(
    parameter int N_PROJ     = 16,
    parameter int ADDR_W     = 4,
    parameter int RST_CYCLES = 8,
    parameter int DIS_CYCLES = 2,
    parameter int IW_W       = IW_W_DEF,
    parameter int OW_W       = OW_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tt_proj_sel_ctrl_if.slave      sel_if,
    output logic [N_PROJ-1:0]      proj_ena,
    input  logic [IW_W-1:0]        pad_iw,
    output logic [IW_W-1:0]        proj_iw,
    input  logic [N_PROJ*OW_W-1:0] proj_ow,
    output logic [OW_W-1:0]        pad_ow
);

    localparam int CNT_MAX = max_int(RST_CYCLES, DIS_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  DIS_LD  = CNT_W'(DIS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [N_PROJ-1:0] ENA_LSB = N_PROJ'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_off_q, pend_off_d;
    logic [N_PROJ-1:0] ena_q, ena_d;
    logic              clk_en_q, clk_en_d;
    logic              rst_force_q, rst_force_d;
    logic              av_q, av_d;
    logic [ADDR_W-1:0] aa_q, aa_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ready;
    logic              accept;
    logic              bad_addr;

    assign ready    = (state_q == IDLE) || (state_q == RUN);
    assign accept   = sel_if.sel_valid && ready;
    assign bad_addr = !sel_if.sel_off && (int'(sel_if.sel_addr) >= N_PROJ);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_addr_d = pend_addr_q;
        pend_off_d  = pend_off_q;
        ena_d       = ena_q;
        clk_en_d    = clk_en_q;
        rst_force_d = rst_force_q;
        av_d        = av_q;
        aa_d        = aa_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    if (bad_addr) begin
                        err_d = 1'b1;
                    end else if (!(sel_if.sel_off && state_q == IDLE)) begin
                        // Any legal command from RUN, even the same tile, re-sequences
                        state_d     = DISABLE;
                        cnt_d       = DIS_LD;
                        pend_addr_d = sel_if.sel_addr;
                        pend_off_d  = sel_if.sel_off;
                        ena_d       = '0;
                        clk_en_d    = 1'b0;
                        rst_force_d = 1'b1;
                        av_d        = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            DISABLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pend_off_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = RESET;
                    cnt_d    = RST_LD;
                    ena_d    = ENA_LSB << pend_addr_q;
                    clk_en_d = 1'b1;
                    aa_d     = pend_addr_q;
                end
            end
            RESET: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d     = RUN;
                    rst_force_d = 1'b0;
                    av_d        = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_addr_q <= '0;
            pend_off_q  <= 1'b0;
            ena_q       <= '0;
            clk_en_q    <= 1'b0;
            rst_force_q <= 1'b1;
            av_q        <= 1'b0;
            aa_q        <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
            pend_off_q  <= pend_off_d;
            ena_q       <= ena_d;
            clk_en_q    <= clk_en_d;
            rst_force_q <= rst_force_d;
            av_q        <= av_d;
            aa_q        <= aa_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign sel_if.sel_ready    = ready;
    assign sel_if.sel_err      = err_q;
    assign sel_if.busy         = busy_q;
    assign sel_if.active_valid = av_q;
    assign sel_if.active_addr  = aa_q;
    assign proj_ena            = ena_q;

    always_comb begin
        proj_iw             = pad_iw;
        proj_iw[IW_CLK_BIT] = pad_iw[IW_CLK_BIT] & clk_en_q;
        proj_iw[IW_RST_BIT] = pad_iw[IW_RST_BIT] & ~rst_force_q;
    end

    tt_ow_mux #(
        .N_PROJ (N_PROJ),
        .ADDR_W (ADDR_W),
        .OW_W   (OW_W)
    ) u_ow_mux (
        .sel_i  (aa_q),
        .en_i   (|ena_q),
        .data_i (proj_ow),
        .data_o (pad_ow)
    );

endmodule

// File: tb/tb_tt_proj_sel_ctrl.sv
// Bench for tt_proj_sel_ctrl: directed table, corner sequences and
// randomized commands against an elapsed-time reference model.
module tb_tt_proj_sel_ctrl;

    localparam int NP = 12;
    localparam int AW = 4;
    localparam int RC = 8;
    localparam int DC = 2;
    localparam int IW = 18;
    localparam int OW = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    proj_ena;
    logic [IW-1:0]    pad_iw;
    logic [IW-1:0]    proj_iw;
    logic [NP*OW-1:0] proj_ow;
    logic [OW-1:0]    pad_ow;

    tt_proj_sel_ctrl_if #(.ADDR_W(AW)) sif ();

    tt_proj_sel_ctrl #(
        .N_PROJ     (NP),
        .ADDR_W     (AW),
        .RST_CYCLES (RC),
        .DIS_CYCLES (DC),
        .IW_W       (IW),
        .OW_W       (OW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_if   (sif),
        .proj_ena (proj_ena),
        .pad_iw   (pad_iw),
        .proj_iw  (proj_iw),
        .proj_ow  (proj_ow),
        .pad_ow   (pad_ow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit force_pins;

    // Reference model: m_k counts edges since the accepted command (-1 = none)
    int m_k, m_cur, m_tgt, m_aa;
    bit m_run, m_off, m_err;

    typedef struct {
        bit          v;
        bit          off;
        logic [3:0]  addr;
        int          reps;
        logic [11:0] ena;
        bit          busy;
        bit          av;
        bit          err;
        bit          rdy;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k   = -1;
        m_run = 1'b0;
        m_cur = 0;
        m_tgt = 0;
        m_off = 1'b0;
        m_aa  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        m_err = 1'b0;
        if (m_k >= 0) begin
            m_k++;
            if (!m_off && m_k == DC) m_aa = m_tgt;
            if (!m_off && m_k == DC + RC) begin
                m_k   = -1;
                m_run = 1'b1;
                m_cur = m_tgt;
            end else if (m_off && m_k == DC) begin
                m_k   = -1;
                m_run = 1'b0;
            end
        end else if (sif.sel_valid) begin
            if (!sif.sel_off && int'(sif.sel_addr) >= NP) begin
                m_err = 1'b1;
            end else if (!(sif.sel_off && !m_run)) begin
                m_k   = 0;
                m_tgt = int'(sif.sel_addr);
                m_off = sif.sel_off;
            end
        end
    endtask

    task automatic check_model();
        int            on;
        bit            ce, rf, av;
        logic [NP-1:0] e_ena;
        logic [OW-1:0] e_ow;
        logic [IW-1:0] e_iw;
        on = -1;
        ce = 1'b0;
        rf = 1'b1;
        av = 1'b0;
        if (m_k >= DC) begin
            on = m_tgt;
            ce = 1'b1;
        end else if (m_k < 0 && m_run) begin
            on = m_cur;
            ce = 1'b1;
            rf = 1'b0;
            av = 1'b1;
        end
        e_ena = '0;
        e_ow  = '0;
        if (on >= 0) begin
            e_ena[on] = 1'b1;
            e_ow      = proj_ow[on*OW +: OW];
        end
        e_iw    = pad_iw;
        e_iw[0] = pad_iw[0] & ce;
        e_iw[1] = pad_iw[1] & ~rf;
        chk("proj_ena", 64'(proj_ena), 64'(e_ena));
        chk("ena_onehot0", 64'($onehot0(proj_ena)), 64'(1));
        chk("busy", 64'(sif.busy), 64'(m_k >= 0));
        chk("active_valid", 64'(sif.active_valid), 64'(av));
        chk("active_addr", 64'(sif.active_addr), 64'(m_aa));
        chk("sel_err", 64'(sif.sel_err), 64'(m_err));
        chk("sel_ready", 64'(sif.sel_ready), 64'(m_k < 0));
        chk("proj_iw", 64'(proj_iw), 64'(e_iw));
        chk("pad_ow", 64'(pad_ow), 64'(e_ow));
    endtask

    task automatic rand_data();
        for (int i = 0; i < NP; i++) proj_ow[i*OW +: OW] = OW'($urandom);
        pad_iw = IW'($urandom);
        if (force_pins) pad_iw[1:0] = 2'b11;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        rand_data();
        #1;
        check_model();
    endtask

    task automatic cmd(input bit v, input bit off, input int addr);
        sif.sel_valid = v;
        sif.sel_off   = off;
        sif.sel_addr  = AW'(addr);
    endtask

    initial begin
        force_pins = 1'b1;
        cmd(0, 0, 0);
        rst_n = 1'b0;
        rand_data();
        model_reset();
        #7;
        chk("rst_ena", 64'(proj_ena), 64'(0));
        chk("rst_busy", 64'(sif.busy), 64'(0));
        chk("rst_av", 64'(sif.active_valid), 64'(0));
        chk("rst_aa", 64'(sif.active_addr), 64'(0));
        chk("rst_err", 64'(sif.sel_err), 64'(0));
        chk("rst_rdy", 64'(sif.sel_ready), 64'(1));
        chk("rst_iw_lo", 64'(proj_iw[1:0]), 64'(0));
        chk("rst_pad_ow", 64'(pad_ow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(row_t'{1, 0, 3,  2, 12'h000, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  8, 12'h008, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h008, 0, 1, 0, 1});
        tbl.push_back(row_t'{1, 0, 5,  2, 12'h000, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  8, 12'h020, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h020, 0, 1, 0, 1});
        tbl.push_back(row_t'{1, 0, 5,  2, 12'h000, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  8, 12'h020, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h020, 0, 1, 0, 1});
        tbl.push_back(row_t'{1, 0, 13, 1, 12'h020, 0, 1, 1, 1});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h020, 0, 1, 0, 1});
        tbl.push_back(row_t'{1, 0, 12, 1, 12'h020, 0, 1, 1, 1});
        tbl.push_back(row_t'{1, 1, 0,  2, 12'h000, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h000, 0, 0, 0, 1});
        tbl.push_back(row_t'{1, 1, 7,  1, 12'h000, 0, 0, 0, 1});
        tbl.push_back(row_t'{1, 0, 15, 1, 12'h000, 0, 0, 1, 1});
        tbl.push_back(row_t'{1, 0, 11, 2, 12'h000, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  8, 12'h800, 1, 0, 0, 0});
        tbl.push_back(row_t'{0, 0, 0,  1, 12'h800, 0, 1, 0, 1});

        foreach (tbl[r]) begin
            cmd(tbl[r].v, tbl[r].off, int'(tbl[r].addr));
            for (int j = 0; j < tbl[r].reps; j++) begin
                step();
                sif.sel_valid = 1'b0;
                chk("tbl_ena", 64'(proj_ena), 64'(tbl[r].ena));
                chk("tbl_busy", 64'(sif.busy), 64'(tbl[r].busy));
                chk("tbl_av", 64'(sif.active_valid), 64'(tbl[r].av));
                chk("tbl_err", 64'(sif.sel_err), 64'(tbl[r].err));
                chk("tbl_rdy", 64'(sif.sel_ready), 64'(tbl[r].rdy));
            end
        end

        // Command held valid through RESET must be ignored
        cmd(1, 0, 2);
        step();
        sif.sel_valid = 1'b0;
        step();
        step();
        cmd(1, 0, 7);
        for (int j = 0; j < 8; j++) begin
            step();
            if (j == 3) chk("held_rdy", 64'(sif.sel_ready), 64'(0));
        end
        sif.sel_valid = 1'b0;
        chk("held_ena", 64'(proj_ena), 64'(12'h004));
        chk("held_av", 64'(sif.active_valid), 64'(1));
        chk("held_aa", 64'(sif.active_addr), 64'(2));

        // Reset asserted while the new tile is held in reset
        cmd(1, 0, 4);
        step();
        sif.sel_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_ena", 64'(proj_ena), 64'(12'h010));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ena", 64'(proj_ena), 64'(0));
        chk("mid_rst_pad_ow", 64'(pad_ow), 64'(0));
        chk("mid_rst_busy", 64'(sif.busy), 64'(0));
        chk("mid_rst_iw1", 64'(proj_iw[1]), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cmd(1, 1, 9);
        step();
        sif.sel_valid = 1'b0;
        chk("post_off_ena", 64'(proj_ena), 64'(0));
        chk("post_off_busy", 64'(sif.busy), 64'(0));
        chk("post_off_rdy", 64'(sif.sel_ready), 64'(1));
        step();

        force_pins = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cmd($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 15)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_proj_sel_ctrl.md
Name: tt_proj_sel_ctrl

Overview:
- Controller that shares the chip's single user-pin interface between N_PROJ tile projects.
- Each tile exposes ena, an 18-bit packed input word {uio_in, ui_in, rst_n, clk} and a 24-bit packed output word {uio_oe, uio_out, uo_out}.
- Accepts select commands, sequences a safe project switch (disable, gated clock, forced reset, run), and drives the one-hot ena vector.
- Routes the pad input word to the tiles and muxes the active tile's output word back to the pads.

Parameters:
- N_PROJ, 16, number of project tiles.
- ADDR_W, 4, select address width; must satisfy 2**ADDR_W >= N_PROJ.
- RST_CYCLES, 8, number of clk cycles the selected tile's rst_n is forced low; valid range 1..255.
- DIS_CYCLES, 2, number of clk cycles all tiles are disabled before a new tile is enabled; must be >= 1.
- IW_W, 18, packed tile input width; bit0 = tile clk, bit1 = tile rst_n.
- OW_W, 24, packed tile output width.

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_valid  in  1  command valid.
- sel_off  in  1  with sel_valid: 1 = deselect all tiles; sel_addr is ignored.
- sel_addr  in  ADDR_W  tile index to activate.
- sel_ready  out  1  command accepted when sel_valid & sel_ready.
- sel_err  out  1  one-cycle pulse on a rejected command.
- busy  out  1  switch sequence in progress.
- active_valid  out  1  a tile is in RUN.
- active_addr  out  ADDR_W  index of the enabled tile.
- proj_ena  out  N_PROJ  one-hot tile enable; all zero when no tile is enabled.
- pad_iw  in  IW_W  packed word from the pins.
- proj_iw  out  IW_W  packed word broadcast to all tiles.
- proj_ow  in  N_PROJ*OW_W  concatenated tile outputs; tile i occupies bits [i*OW_W +: OW_W].
- pad_ow  out  OW_W  packed word to the pins.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state = IDLE; proj_ena = 0; active_valid = 0; active_addr = 0; busy = 0; sel_err = 0; clk_en = 0; rst_force = 1.
- States and transitions:
  - IDLE → DISABLE on an accepted valid select.
  - DISABLE holds DIS_CYCLES cycles, then:
    - → RESET if the pending command is a select;
    - → IDLE if the pending command is an off.
  - RESET holds RST_CYCLES cycles → RUN.
  - RUN → DISABLE on any accepted command, including a reselect of the same index (full re-reset).
  - IDLE + accepted off: stays IDLE, no effect.
- Handshake:
  - sel_ready = 1 in IDLE and RUN only.
  - Commands presented while busy are ignored: not queued, no sel_err.
  - The command is captured on the accept edge; sel_addr may change afterwards.
- Error:
  - Accepted command with sel_off = 0 and sel_addr >= N_PROJ: sel_err pulses high the next cycle.
  - State, ena and routing are unchanged.
- Outputs per state (all registered):
  - IDLE: proj_ena = 0; clk_en = 0; rst_force = 1; active_valid = 0.
  - DISABLE: proj_ena = 0; clk_en = 0; rst_force = 1; busy = 1; active_valid = 0.
  - RESET: proj_ena = onehot(pending); clk_en = 1; rst_force = 1; busy = 1; active_addr = pending.
  - RUN: proj_ena unchanged; rst_force = 0; busy = 0; active_valid = 1.
- Routing (combinational):
  - proj_iw[0] = pad_iw[0] & clk_en.
  - proj_iw[1] = pad_iw[1] & ~rst_force.
  - proj_iw[IW_W-1:2] = pad_iw[IW_W-1:2].
  - pad_ow = proj_ow slice of active_addr when proj_ena != 0, else 0.
- Latency: accept edge to RUN = DIS_CYCLES + RST_CYCLES cycles; first cycle with a non-zero proj_ena = DIS_CYCLES + 1.
- proj_ena is never non-zero on more than one bit, and never changes between two different non-zero values without at least DIS_CYCLES all-zero cycles between them.
- Reset asserted mid-sequence: proj_ena is cleared immediately; the pending command is discarded.
- Counter: ceil(log2(max(RST_CYCLES, DIS_CYCLES)+1)) bits; it is reloaded on every state entry and never wraps.

Decomposition:
- Shared package tt_ctrl_pkg:
  - state enum {IDLE, DISABLE, RESET, RUN};
  - IW_CLK_BIT = 0, IW_RST_BIT = 1;
  - default IW_W and OW_W.
- One natural sub-module: tt_ow_mux, a parameterised N_PROJ:1 OW_W-wide output mux with a zero default.

Test Plan:
- Reset, then sel_addr=3 accepted → proj_ena=0 for 2 cycles; proj_ena=16'h0008 with proj_iw[1]=0 for 8 cycles; then RUN, active_valid=1, busy=0, pad_ow=proj_ow[3].
- In RUN on tile 3, select 5 → proj_ena=0 and proj_iw[0]=0 for 2 cycles, then 16'h0020; no cycle has two ena bits set.
- sel_addr=3 while RUN on tile 3 → full 2+8 re-reset sequence; proj_iw[1] forced 0 for 8 cycles.
- With N_PROJ=12, sel_addr=13 → sel_err pulses 1 cycle; proj_ena, state and pad_ow are unchanged.
- sel_valid held high during RESET with a different address → ignored: sel_ready=0, original tile reaches RUN.
- rst_n asserted during RESET → proj_ena=0 and pad_ow=0 at once; after release, state is IDLE and sel_off from IDLE leaves outputs unchanged.
